// File: rtl/pearray_axil_ctrl.sv
// AXI4-Lite control/status slave for the PE-array engine: start/done handshake, sticky status, run stats.
// Optional feature macro: PEARRAY_PERF_CNT_EN (adds the CYCLES latency counter at offset 0x8).
module pearray_axil_ctrl #(
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            start,
  input  logic                            done
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_awready, r_arready, r_bvalid, r_rvalid;
  logic [31:0] r_rdata;
  logic        r_start, r_done, r_drop;
  logic [31:0] r_runs;
  logic [31:0] w_cycles;

  logic        w_wr_hs, w_rd_hs, w_ctrl_wr, w_start_req, w_clr;
  logic        w_busy, w_accept, w_done_ev;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  // Handshakes complete on the edge where the registered ready is high and the master is still valid.
  assign w_wr_hs     = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_rd_hs     = r_arready & S_AXI_ARVALID;
  assign w_ctrl_wr   = w_wr_hs & (S_AXI_AWADDR[3:2] == 2'd0) & S_AXI_WSTRB[0];
  assign w_start_req = w_ctrl_wr & S_AXI_WDATA[0];
  assign w_clr       = w_ctrl_wr & S_AXI_WDATA[1];

  assign w_busy    = (r_state == S_RUN);
  assign w_done_ev = done & w_busy;
  assign w_accept  = w_start_req & (~w_busy | done);

  assign w_unused = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WDATA[31:2], S_AXI_WSTRB[3:1]};

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_RUN;
      S_RUN:  if (w_accept) w_state_nxt = S_RUN;
              else if (done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_awready <= 1'b0;
      r_arready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_drop    <= 1'b0;
      r_runs    <= '0;
    end else begin
      // Ready is a single-cycle pulse; the !ready term stops it repeating while valid is still held.
      r_awready <= S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid & ~r_awready;
      r_arready <= S_AXI_ARVALID & ~r_rvalid & ~r_arready;

      if (w_wr_hs)           r_bvalid <= 1'b1;
      else if (S_AXI_BREADY) r_bvalid <= 1'b0;

      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_mux;
      end else if (S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end

      r_start <= w_accept;

      // A fresh run clears DONE even if the old run finishes on the same edge.
      if (w_accept)       r_done <= 1'b0;
      else if (w_done_ev) r_done <= 1'b1;
      else if (w_clr)     r_done <= 1'b0;

      if (w_start_req & ~w_accept) r_drop <= 1'b1;
      else if (w_clr)              r_drop <= 1'b0;

      if (w_done_ev) r_runs <= r_runs + 32'd1;
    end
  end

`ifdef PEARRAY_PERF_CNT_EN
  logic [31:0] r_cycles;

  // The start-pulse cycle itself is not counted, so a done N cycles after start yields N.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET)                         r_cycles <= '0;
    else if (w_accept)                        r_cycles <= '0;
    else if (w_busy & ~r_start & ~&r_cycles)  r_cycles <= r_cycles + 32'd1;
  end

  assign w_cycles = r_cycles;
`else
  assign w_cycles = '0;
`endif

  always_comb begin
    w_rd_mux = '0;
    case (S_AXI_ARADDR[3:2])
      2'd1:    w_rd_mux = {29'd0, r_drop, r_done, w_busy};
      2'd2:    w_rd_mux = w_cycles;
      2'd3:    w_rd_mux = r_runs;
      default: w_rd_mux = '0;
    endcase
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign start         = r_start;

endmodule

// File: tb/tb_pearray_axil_ctrl.sv
// Self-checking bench for pearray_axil_ctrl: randomized register traffic against an event-level model.
module tb_pearray_axil_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        start, done;

  always #5 clk = ~clk;

  pearray_axil_ctrl dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .start(start), .done(done)
  );

  int vec = 0, err = 0;
  int cyc = 0, start_cnt = 0, start_cyc = 0, hs_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (start === 1'b1) begin start_cnt++; start_cyc = cyc; end

  // Event-level model of the software-visible state.
  bit          m_busy, m_done, m_drop;
  logic [31:0] m_runs, m_cycles;
  int          m_start_cyc;

  function automatic logic [31:0] model_reg(input logic [3:0] a);
    case (a[3:2])
      2'd1: return {29'd0, m_drop, m_done, m_busy};
`ifdef PEARRAY_PERF_CNT_EN
      2'd2: return m_cycles;
`else
      2'd2: return 32'd0;
`endif
      2'd3: return m_runs;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_drop = 0; m_runs = 0; m_cycles = 0; m_start_cyc = 0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit wd, output logic [1:0] resp);
    bit ok = 0;
    resp = 2'bxx;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready === 1'b1 && wready === 1'b1) begin ok = 1; break; end
    end
    if (ok) begin
      if (wd) done = 1;
      hs_cyc = cyc;
    end else begin
      vec++; err++; $display("FAIL aw_timeout got awready=%b required 1", awready);
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; done = 0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bvalid === 1'b1) begin ok = 1; resp = bresp; break; end
    end
    if (!ok) begin vec++; err++; $display("FAIL b_timeout got bvalid=%b required 1", bvalid); end
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ok = 0;
    d = 'x; resp = 2'bxx;
    @(posedge clk); #1;
    araddr = a; arvalid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready === 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin vec++; err++; $display("FAIL ar_timeout got arready=%b required 1", arready); end
    @(posedge clk); #1;
    arvalid = 0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rvalid === 1'b1) begin ok = 1; d = rdata; resp = rresp; break; end
    end
    if (!ok) begin vec++; err++; $display("FAIL r_timeout got rvalid=%b required 1", rvalid); end
    @(posedge clk); #1;
  endtask

  // CTRL write with optional engine done in the handshake cycle; returns pulses seen vs expected.
  task automatic do_ctrl(input logic [31:0] d, input bit wd, output int got, output int exp);
    bit acc, dev;
    int p0;
    logic [1:0] resp;
    acc = d[0] && (!m_busy || wd);
    dev = wd && m_busy;
    p0  = start_cnt;
    axi_write(4'h0, d, 4'hF, wd, resp);
    if (dev) begin m_busy = 0; m_done = 1; m_runs++; m_cycles = 32'(hs_cyc - m_start_cyc); end
    if (d[1]) begin m_drop = 0; if (!dev) m_done = 0; end
    if (d[0]) begin
      if (acc) begin m_busy = 1; m_done = 0; m_cycles = 0; m_start_cyc = start_cyc; end
      else m_drop = 1;
    end
    got = start_cnt - p0;
    exp = acc ? 1 : 0;
  endtask

  task automatic done_at(input int target);
    int dc;
    while (cyc < target) begin @(posedge clk); #1; end
    done = 1; dc = cyc;
    @(posedge clk); #1;
    done = 0;
    if (m_busy) begin m_busy = 0; m_done = 1; m_runs++; m_cycles = 32'(dc - m_start_cyc); end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    logic [3:0] a;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++;
    if ({awready, wready, bvalid, arready, rvalid, start} !== 6'b0 || rdata !== 32'd0 ||
        bresp !== 2'b00 || rresp !== 2'b00) begin
      err++; $display("FAIL reset_outputs got rdy/vld/start=%b rdata=%h required all 0",
                      {awready, wready, bvalid, arready, rvalid, start}, rdata);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      a = 4'(i * 4);
      axi_read(a, d, r);
      vec++;
      if (d !== 32'd0 || r !== 2'b00) begin
        err++; $display("FAIL reset_read addr=%h got %h/%b required 00000000/00", a, d, r);
      end
    end
    vec++;
    if (start_cnt != 0) begin err++; $display("FAIL reset_start got %0d pulses required 0", start_cnt); end
  endtask

  task automatic test_run(input int n);
    int got, exp;
    logic [31:0] d; logic [1:0] r;
    do_ctrl(32'h1, 0, got, exp);
    vec++;
    if (got != 1) begin err++; $display("FAIL run_pulse got %0d required 1", got); end
    axi_read(4'h4, d, r);
    vec++;
    if (d !== 32'h1) begin err++; $display("FAIL run_busy got %h required 00000001", d); end
    done_at(m_start_cyc + n);
    axi_read(4'h4, d, r);
    vec++;
    if (d !== 32'h2) begin err++; $display("FAIL run_status got %h required 00000002", d); end
    axi_read(4'h8, d, r);
    vec++;
`ifdef PEARRAY_PERF_CNT_EN
    if (d !== 32'(n)) begin err++; $display("FAIL run_cycles got %0d required %0d", d, n); end
`else
    if (d !== 32'd0) begin err++; $display("FAIL run_cycles got %0d required 0", d); end
`endif
    axi_read(4'hC, d, r);
    vec++;
    if (d !== m_runs) begin err++; $display("FAIL run_runs got %0d required %0d", d, m_runs); end
  endtask

  task automatic test_drop();
    int got, exp;
    logic [31:0] d; logic [1:0] r;
    do_ctrl(32'h1, 0, got, exp);
    do_ctrl(32'h1, 0, got, exp);
    vec++;
    if (got != 0 || exp != 0) begin err++; $display("FAIL drop_pulse got %0d required 0", got); end
    axi_read(4'h4, d, r);
    vec++;
    if (d !== 32'h5) begin err++; $display("FAIL drop_status got %h required 00000005", d); end
    do_ctrl(32'h2, 0, got, exp);
    axi_read(4'h4, d, r);
    vec++;
    if (d !== 32'h1) begin err++; $display("FAIL drop_clr got %h required 00000001", d); end
    done_at(cyc + 2);
  endtask

  task automatic test_back_to_back();
    int got, exp;
    logic [31:0] d, runs0; logic [1:0] r;
    do_ctrl(32'h1, 0, got, exp);
    repeat ($urandom_range(2, 6)) @(posedge clk);
    #1;
    runs0 = m_runs;
    do_ctrl(32'h1, 1, got, exp);
    vec++;
    if (got != 1) begin err++; $display("FAIL b2b_pulse got %0d required 1", got); end
    axi_read(4'h4, d, r);
    vec++;
    if (d !== 32'h1) begin err++; $display("FAIL b2b_status got %h required 00000001", d); end
    axi_read(4'hC, d, r);
    vec++;
    if (d !== runs0 + 32'd1) begin err++; $display("FAIL b2b_runs got %0d required %0d", d, runs0 + 1); end
    done_at(cyc + $urandom_range(1, 8));
    axi_read(4'h8, d, r);
    vec++;
    if (d !== model_reg(4'h8)) begin err++; $display("FAIL b2b_cycles got %0d required %0d", d, model_reg(4'h8)); end
  endtask

  task automatic test_ignored();
    int p0;
    logic [31:0] d; logic [1:0] r;
    logic [7:0] alias_a;
    p0 = start_cnt;
    axi_write(4'h0, 32'h3, 4'h0, 0, r);
    vec++;
    if (r !== 2'b00) begin err++; $display("FAIL strb0_bresp got %b required 00", r); end
    for (int i = 1; i < 4; i++) begin
      axi_write(4'(i * 4), 32'hFFFF_FFFF, 4'hF, 0, r);
      vec++;
      if (r !== 2'b00) begin err++; $display("FAIL ro_bresp addr=%0d got %b required 00", i * 4, r); end
    end
    vec++;
    if (start_cnt != p0) begin err++; $display("FAIL ignored_pulse got %0d required 0", start_cnt - p0); end
    for (int i = 1; i < 4; i++) begin
      axi_read(4'(i * 4), d, r);
      vec++;
      if (d !== model_reg(4'(i * 4))) begin
        err++; $display("FAIL ignored_state addr=%0d got %h required %h", i * 4, d, model_reg(4'(i * 4)));
      end
    end
    alias_a = 8'h10;
    axi_read(alias_a[3:0], d, r);
    vec++;
    if (d !== 32'd0 || r !== 2'b00) begin err++; $display("FAIL alias10 got %h/%b required 00000000/00", d, r); end
    alias_a = 8'h14;
    axi_read(alias_a[3:0], d, r);
    vec++;
    if (d !== model_reg(4'h4)) begin err++; $display("FAIL alias14 got %h required %h", d, model_reg(4'h4)); end
  endtask

  task automatic test_random();
    int got, exp, op;
    logic [31:0] d; logic [1:0] r;
    logic [3:0] a;
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          do_ctrl(32'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), got, exp);
          vec++;
          if (got != exp) begin err++; $display("FAIL rnd_pulse it=%0d got %0d required %0d", it, got, exp); end
        end
        1: done_at(cyc + $urandom_range(0, 6));
        2, 3: begin
          a = 4'($urandom_range(0, 3) * 4);
          axi_read(a, d, r);
          if (!(a == 4'h8 && m_busy)) begin
            vec++;
            if (d !== model_reg(a)) begin
              err++; $display("FAIL rnd_read it=%0d addr=%h got %h required %h", it, a, d, model_reg(a));
            end
          end
        end
        default: begin
          repeat ($urandom_range(0, 5)) @(posedge clk);
          #1;
        end
      endcase
    end
  endtask

  task automatic test_bp();
    bit ok = 0;
    logic [31:0] d; logic [1:0] r;
    bready = 0;
    @(posedge clk); #1;
    awaddr = 4'h0; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready === 1'b1) begin ok = 1; break; end
    end
    vec++;
    if (!ok) begin err++; $display("FAIL bp_aw_timeout got awready=%b required 1", awready); end
    @(posedge clk); #1;
    m_drop = 0; m_done = 0;
    awaddr = 4'h4; wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        err++; $display("FAIL bp_hold cyc=%0d got bvalid=%b awready=%b required 1/0", i, bvalid, awready);
      end
    end
    @(posedge clk); #1;
    bready = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready === 1'b1) begin ok = 1; break; end
    end
    vec++;
    if (!ok) begin err++; $display("FAIL bp_next_aw got awready=%b required 1", awready); end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    repeat (3) @(posedge clk);
    #1;
    axi_read(4'h4, d, r);
    vec++;
    if (d !== model_reg(4'h4)) begin err++; $display("FAIL bp_status got %h required %h", d, model_reg(4'h4)); end
  endtask

  task automatic test_reset_midrun();
    int got, exp;
    logic [31:0] d; logic [1:0] r;
    if (m_busy) done_at(cyc);
    do_ctrl(32'h1, 0, got, exp);
    repeat ($urandom_range(1, 5)) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    @(negedge clk);
    vec++;
    if (start !== 1'b0) begin err++; $display("FAIL rstrun_start got %b required 0", start); end
    axi_read(4'h4, d, r);
    vec++;
    if (d !== 32'h0) begin err++; $display("FAIL rstrun_status got %h required 00000000", d); end
    axi_read(4'hC, d, r);
    vec++;
    if (d !== 32'h0) begin err++; $display("FAIL rstrun_runs got %h required 00000000", d); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 1;
    araddr = 0; arvalid = 0; rready = 1; done = 0;
    model_reset();
    test_reset();
    test_run(20);
    for (int i = 0; i < 3; i++) test_run($urandom_range(10, 40));
    test_drop();
    test_back_to_back();
    test_ignored();
    test_random();
    test_bp();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/pearray_axil_ctrl.md
# pearray_axil_ctrl

AXI4-Lite control/status slave sitting directly upstream of the PE-array matrix-vector engine. It turns host register writes into the engine's one-cycle `start` pulse, tracks the run with a busy flag, captures the engine's one-cycle `done` pulse into a sticky status bit, and reports run latency and run count to software.

## Interface
Parameters:
- `C_S_AXI_ADDR_WIDTH`, 4: AXI-Lite address width; registers decoded on `addr[3:2]`.
- `C_S_AXI_DATA_WIDTH`, 32: data width; fixed at 32.

Ports:
- `S_AXI_ACLK` in 1: single clock for all logic.
- `S_AXI_ARESET` in 1: synchronous, active-high reset.
- `S_AXI_AWADDR` in 4, `S_AXI_AWVALID` in 1, `S_AXI_AWREADY` out 1: write address channel.
- `S_AXI_WDATA` in 32, `S_AXI_WSTRB` in 4, `S_AXI_WVALID` in 1, `S_AXI_WREADY` out 1: write data channel.
- `S_AXI_BRESP` out 2, `S_AXI_BVALID` out 1, `S_AXI_BREADY` in 1: write response.
- `S_AXI_ARADDR` in 4, `S_AXI_ARVALID` in 1, `S_AXI_ARREADY` out 1: read address.
- `S_AXI_RDATA` out 32, `S_AXI_RRESP` out 2, `S_AXI_RVALID` out 1, `S_AXI_RREADY` in 1: read data.
- `start` out 1: one-cycle launch pulse to the engine.
- `done` in 1: one-cycle completion pulse from the engine.

## Operation
- Register map (byte offsets); all registers read 0 on unmapped bits.
  - 0x0 CTRL (write-only, reads 0): bit0 START, bit1 CLR.
  - 0x4 STATUS (RO): bit0 BUSY, bit1 DONE (sticky), bit2 DROP (sticky).
  - 0x8 CYCLES (RO): latency of the last or current run.
  - 0xC RUNS (RO): completed runs, 32-bit, wraps 0xFFFFFFFF -> 0.
- Writes take effect only when `WSTRB[0]`=1; writes to 0x4/0x8/0xC are ignored; all responses OKAY (`BRESP`=`RRESP`=2'b00), including unmapped addresses.
- START=1 is accepted when BUSY=0, or when `done`=1 in the same cycle. Accept: `start` pulses, BUSY<=1, DONE<=0, CYCLES<=0. Otherwise DROP<=1 and no pulse.
- CLR=1 clears DONE and DROP. If `done` arrives in the same cycle, DONE is set (set wins). START and CLR may be written together: CLR applies first, then START.
- `done` while BUSY=1: BUSY<=0, DONE<=1, RUNS<=RUNS+1. `done` while BUSY=0 is ignored.
- Run state is two-state: IDLE (BUSY=0) and RUN (BUSY=1). IDLE->RUN on an accepted START; RUN->IDLE on `done`.

## Timing
- Reset values: all AXI ready/valid outputs 0, `BRESP`/`RRESP`/`RDATA` 0, `start` 0, BUSY/DONE/DROP/CYCLES/RUNS 0. A reset during a run returns the block to IDLE immediately; a pending `start` pulse is cancelled.
- Write: `AWREADY` and `WREADY` pulse high together for one cycle when `AWVALID`&`WVALID`&!`BVALID`. The register update occurs on that edge. `BVALID` rises on the next cycle and holds until `BREADY`. Only one write is outstanding at a time.
- `start` is registered: it is high for exactly one cycle, starting the cycle after the write handshake, coincident with BUSY=1.
- Read: `ARREADY` pulses for one cycle when `ARVALID`&!`RVALID`. `RDATA` is registered with `RVALID` the next cycle and holds until `RREADY`. A read returns state as of the handshake edge.
- CYCLES: loaded to 0 on the `start` edge. It increments once per cycle while BUSY=1, up to and including the cycle `done` is sampled, then freezes. If `done` arrives N cycles after `start`, CYCLES=N. Saturates at 0xFFFFFFFF.

## Configuration
- `PEARRAY_PERF_CNT_EN` defined: the CYCLES counter is implemented as above.
- Not defined: no counter logic; offset 0x8 reads 0x00000000. All other behaviour is unchanged.

## Test plan
- Reset, then read all four offsets -> all 0x00000000; `start` stays 0.
- Write CTRL=0x1; drive `done` 20 cycles after `start` -> one `start` pulse; STATUS 0x1 during the run, then 0x2; CYCLES=20 (0 with macro off); RUNS=1.
- Write START while BUSY=1 -> no `start` pulse, STATUS=0x5. Then write CTRL=0x2 -> STATUS=0x1.
- Write START in the same cycle `done` is high -> new `start` pulse; RUNS increments; BUSY=1, DONE=0.
- Write CTRL=0x1 with `WSTRB`=0x0; write to 0x4; read 0x10 alias -> no pulse, register state unchanged, `BRESP`=0.
- Hold `BREADY`=0 for 5 cycles after a write -> `BVALID` held; next `AWREADY` not asserted until B completes. Assert reset mid-run -> BUSY=0 and RUNS=0 next cycle.
